// File: rtl/serial_deser_pkg.sv
// Shared encodings, control-state enum and word-length helper for the serial deserializer.
// Word length grows by one parity bit when SERIAL_DESER_PARITY_EN is defined.
package serial_deser_pkg;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_e;

`ifdef SERIAL_DESER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int word_len(input int dw);
        return PARITY_EN ? dw + 1 : dw;
    endfunction

endpackage

// File: rtl/deser_bitcnt.sv
// Bit counter: counts accepted bits, wraps to 0 after TERM, clears on abort.
// Registered count, combinational terminal flag; never stalls.
module deser_bitcnt #(
    parameter int CNTWIDTH = 3,
    parameter int TERM     = 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [CNTWIDTH-1:0] cnt_o,
    output logic                term_o
);

    logic [CNTWIDTH-1:0] cnt_q;
    logic [CNTWIDTH-1:0] cnt_d;

    assign term_o = (cnt_q == CNTWIDTH'(TERM));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = term_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler (MSB/LSB-first) with valid/ready output register, sticky overrun; optional parity via SERIAL_DESER_PARITY_EN.
// Q_VALID one cycle after the last bit; input never stalls, a word completing while Q is unconsumed is dropped and flags OVERRUN.
module serial_deserializer
    import serial_deser_pkg::*;
#(
    parameter int DATAWIDTH = 4,
    parameter int CNTWIDTH  = $clog2(DATAWIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 SIN,
    input  logic                 SIN_VALID,
    input  logic                 DIR,
    input  logic                 ABORT,
    output logic [DATAWIDTH-1:0] Q,
    output logic                 Q_VALID,
    input  logic                 Q_READY,
    output logic                 OVERRUN,
    input  logic                 CLR_OVR,
    output logic                 PERR
);

    localparam int WORDLEN = word_len(DATAWIDTH);

    logic                 accept;
    logic                 last_bit;
    logic                 first_bit;
    logic                 term;
    logic                 shift_en;
    logic                 dir_eff;
    logic                 dir_q, dir_d;
    logic [CNTWIDTH-1:0]  cnt;
    logic [DATAWIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [DATAWIDTH-1:0] word;
    logic                 word_perr;
    logic [DATAWIDTH-1:0] q_q, q_d;
    logic                 ovr_q, ovr_d;
    logic                 perr_q, perr_d;
    logic                 load, drop;
    state_e               state_q, state_d;

    deser_bitcnt #(
        .CNTWIDTH (CNTWIDTH),
        .TERM     (WORDLEN - 1)
    ) u_bitcnt (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .inc_i   (accept),
        .clr_i   (ABORT),
        .cnt_o   (cnt),
        .term_o  (term)
    );

    assign accept    = SIN_VALID & ~ABORT;
    assign last_bit  = accept & term;
    assign first_bit = (cnt == '0);
    // DIR is only honoured on the first bit; later bits follow the latched value.
    assign dir_eff   = first_bit ? DIR : dir_q;
    assign dir_d     = (accept && first_bit) ? DIR : dir_q;
    assign sr_shift  = (dir_eff == DIR_LSB_FIRST) ? {SIN, sr_q[DATAWIDTH-1:1]}
                                                  : {sr_q[DATAWIDTH-2:0], SIN};

`ifdef SERIAL_DESER_PARITY_EN
    // The trailing parity bit is checked, not shifted in.
    assign shift_en  = accept & ~term;
    assign word      = sr_q;
    assign word_perr = (^sr_q) ^ SIN;
`else
    assign shift_en  = accept;
    assign word      = sr_shift;
    assign word_perr = 1'b0;
`endif

    always_comb begin
        sr_d = sr_q;
        if (ABORT) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = sr_shift;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (last_bit) begin
                    load    = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (last_bit) begin
                    load = Q_READY;
                    drop = ~Q_READY;
                end else if (Q_READY) begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign q_d    = load ? word : q_q;
    assign perr_d = load ? word_perr : perr_q;
    assign ovr_d  = drop | (ovr_q & ~CLR_OVR);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sr_q    <= '0;
            dir_q   <= DIR_MSB_FIRST;
            q_q     <= '0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
            state_q <= S_COLLECT;
        end else begin
            sr_q    <= sr_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
            state_q <= state_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = (state_q == S_HOLD);
    assign OVERRUN = ovr_q;
    assign PERR    = perr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: queue-based word model compared every cycle, directed scenarios plus random traffic.
module tb_serial_deserializer;

    localparam int DW = 4;
`ifdef SERIAL_DESER_PARITY_EN
    localparam int WL = DW + 1;
`else
    localparam int WL = DW;
`endif

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          SIN, SIN_VALID, DIR, ABORT, Q_READY, CLR_OVR;
    logic [DW-1:0] Q;
    logic          Q_VALID, OVERRUN, PERR;

    serial_deserializer #(.DATAWIDTH(DW)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .SIN       (SIN),
        .SIN_VALID (SIN_VALID),
        .DIR       (DIR),
        .ABORT     (ABORT),
        .Q         (Q),
        .Q_VALID   (Q_VALID),
        .Q_READY   (Q_READY),
        .OVERRUN   (OVERRUN),
        .CLR_OVR   (CLR_OVR),
        .PERR      (PERR)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collect the bits of a word in arrival order, build the word at the end.
    logic [DW-1:0] m_q;
    bit            m_vld, m_ovr, m_perr, m_dir;
    bit            m_bits[$];

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_q    = '0;
            m_vld  = 1'b0;
            m_ovr  = 1'b0;
            m_perr = 1'b0;
            m_dir  = 1'b1;
            m_bits.delete();
        end else begin : model_step
            bit            done, ovr_set, p;
            logic [DW-1:0] w;
            done    = 1'b0;
            ovr_set = 1'b0;
            if (ABORT) begin
                m_bits.delete();
            end else if (SIN_VALID) begin
                if (m_bits.size() == 0) m_dir = DIR;
                m_bits.push_back(SIN);
                if (m_bits.size() == WL) begin
                    w = '0;
                    p = 1'b0;
                    for (int i = 0; i < DW; i++) begin
                        if (m_dir) w[DW-1-i] = m_bits[i];
                        else       w[i]      = m_bits[i];
                    end
                    if (WL > DW) p = (^w) ^ m_bits[DW];
                    m_bits.delete();
                    if (!m_vld || Q_READY) begin
                        m_q    = w;
                        m_perr = p;
                        m_vld  = 1'b1;
                        done   = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
            if (!done && m_vld && Q_READY) m_vld = 1'b0;
            m_ovr = (m_ovr && !CLR_OVR) || ovr_set;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("cyc_q",       Q,       m_q);
            chk("cyc_q_valid", Q_VALID, m_vld);
            chk("cyc_overrun", OVERRUN, m_ovr);
            chk("cyc_perr",    PERR,    m_perr);
        end
    end

    task automatic drive(input bit sv, input bit s, input bit d, input bit ab,
                         input bit rdy, input bit clr);
        SIN_VALID = sv;
        SIN       = s;
        DIR       = d;
        ABORT     = ab;
        Q_READY   = rdy;
        CLR_OVR   = clr;
        @(negedge CLK);
    endtask

    // bits[DW-1] is sent first; parity (if enabled) is appended as the last bit.
    task automatic send_word(input logic [DW-1:0] bits, input bit d, input bit rdy_last);
        for (int i = DW - 1; i >= 0; i--)
            drive(1'b1, bits[i], d, 1'b0, (i == 0 && WL == DW) ? rdy_last : 1'b0, 1'b0);
`ifdef SERIAL_DESER_PARITY_EN
        drive(1'b1, ^bits, d, 1'b0, rdy_last, 1'b0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic consume();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        RESET_N = 1'b0;
        SIN = 0; SIN_VALID = 0; DIR = 1; ABORT = 0; Q_READY = 0; CLR_OVR = 0;
        repeat (2) @(negedge CLK);
        chk("rst_q",       Q,       '0);
        chk("rst_q_valid", Q_VALID, 1'b0);
        chk("rst_overrun", OVERRUN, 1'b0);
        chk("rst_perr",    PERR,    1'b0);
        RESET_N = 1'b1;
        cmp_en  = 1'b1;

        // MSB-first word, held until consumed
        send_word(4'b1011, 1'b1, 1'b0);
        chk("msb_q",       Q,       4'b1011);
        chk("msb_model",   m_q,     4'b1011);
        chk("msb_valid",   Q_VALID, 1'b1);
        idle(3);
        chk("msb_hold",    Q_VALID, 1'b1);
        consume();
        chk("msb_release", Q_VALID, 1'b0);
        chk("msb_keep_q",  Q,       4'b1011);

        // LSB-first word, then DIR toggled mid-word
        send_word(4'b1011, 1'b0, 1'b0);
        chk("lsb_q",     Q,   4'b1101);
        chk("lsb_model", m_q, 4'b1101);
        consume();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_DESER_PARITY_EN
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        chk("dirtog_q",     Q,       4'b1101);
        chk("dirtog_valid", Q_VALID, 1'b1);
        consume();

        // overrun, clear, then completion coincident with transfer
        send_word(4'b1011, 1'b1, 1'b0);
        send_word(4'b0110, 1'b1, 1'b0);
        chk("ovr_q",       Q,       4'b1011);
        chk("ovr_set",     OVERRUN, 1'b1);
        chk("ovr_valid",   Q_VALID, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear",   OVERRUN, 1'b0);
        send_word(4'b0110, 1'b1, 1'b1);
        chk("xfer_q",      Q,       4'b0110);
        chk("xfer_valid",  Q_VALID, 1'b1);
        chk("xfer_no_ovr", OVERRUN, 1'b0);
        consume();

        // ABORT wins over SIN_VALID and restarts the word
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_no_valid", Q_VALID, 1'b0);
        send_word(4'b0110, 1'b1, 1'b0);
        chk("abort_q",       Q,       4'b0110);
        chk("abort_valid",   Q_VALID, 1'b1);
        chk("abort_no_ovr",  OVERRUN, 1'b0);

        // asynchronous reset mid-word with state to clear
        send_word(4'b1111, 1'b1, 1'b0);
        chk("pre_rst_ovr", OVERRUN, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_q",       Q,       '0);
        chk("arst_valid",   Q_VALID, 1'b0);
        chk("arst_overrun", OVERRUN, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;
        send_word(4'b1001, 1'b1, 1'b0);
        chk("post_rst_q",     Q,       4'b1001);
        chk("post_rst_valid", Q_VALID, 1'b1);
        consume();

`ifdef SERIAL_DESER_PARITY_EN
        send_word(4'b1011, 1'b1, 1'b0);
        chk("par_ok_q",    Q,    4'b1011);
        chk("par_ok_perr", PERR, 1'b0);
        consume();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("par_bad_q",     Q,       4'b1011);
        chk("par_bad_perr",  PERR,    1'b1);
        chk("par_bad_valid", Q_VALID, 1'b1);
        consume();
`endif

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0);
        end
        idle(2);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
